// File: rtl/microsequencer.sv
// Microinstruction sequencer: T-state counter, fixed fetch words in T0/T1,
// microcode ROM pass-through from T2, plus run/halt/step control.
module microsequencer #(
    parameter int unsigned OPCODE_W      = 8,
    parameter logic [15:0] FETCH0        = 16'h0040,
    parameter logic [15:0] FETCH1        = 16'h3480,
    parameter logic [15:0] NOP_WORD      = 16'h7000,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [15:0]           rom_data,
    output logic [OPCODE_W+2:0]   rom_addr,
    output logic [15:0]           uinstr,
    output logic [2:0]            tstate,
    input  logic                  run,
    input  logic                  step_req,
    output logic                  step_ack,
    output logic                  halted,
    output logic [15:0]           instr_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STEP,
        S_HALT
    } mode_t;

    localparam mode_t RESET_MODE = START_RUNNING ? S_RUN : S_HALT;

    mode_t      mode;
    logic [2:0] t;
    logic       rt;
    logic       complete;

    always_comb begin
        uinstr = rom_data;
        if (mode == S_HALT)
            uinstr = NOP_WORD;
        else if (t == 3'd0)
            uinstr = FETCH0;
        else if (t == 3'd1)
            uinstr = FETCH1;
    end

    // RT is decoded from the muxed word, so the fetch words can never end an instruction.
    assign rt       = !uinstr[15] && uinstr[11];
    assign complete = (mode != S_HALT) && ((rt && (t >= 3'd2)) || (t == 3'd7));

    assign rom_addr = {opcode, t};
    assign tstate   = t;
    assign halted   = (mode == S_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t           <= '0;
            mode        <= RESET_MODE;
            step_ack    <= 1'b0;
            instr_count <= '0;
        end else begin
            step_ack <= 1'b0;
            if (mode == S_HALT) begin
                t <= '0;
                if (run)
                    mode <= S_RUN;
                else if (step_req)
                    mode <= S_STEP;
            end else if (complete) begin
                t           <= '0;
                instr_count <= instr_count + 16'd1;
                if (mode == S_STEP)
                    step_ack <= 1'b1;
                mode <= run ? S_RUN : S_HALT;
            end else begin
                t <= t + 3'd1;
            end
        end
    end

endmodule
